// File: rtl/lvds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lvds_pkg: shared state encoding and default timing for the panel sequencer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lvds_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_OFF     = 3'd0;
  localparam logic [STATE_W-1:0] ST_VDD     = 3'd1;
  localparam logic [STATE_W-1:0] ST_LVDS    = 3'd2;
  localparam logic [STATE_W-1:0] ST_VIDEO   = 3'd3;
  localparam logic [STATE_W-1:0] ST_ON      = 3'd4;
  localparam logic [STATE_W-1:0] ST_BL_DN   = 3'd5;
  localparam logic [STATE_W-1:0] ST_LVDS_DN = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_OFF     = ST_OFF,
    S_VDD     = ST_VDD,
    S_LVDS    = ST_LVDS,
    S_VIDEO   = ST_VIDEO,
    S_ON      = ST_ON,
    S_BL_DN   = ST_BL_DN,
    S_LVDS_DN = ST_LVDS_DN
  } state_e;

  localparam logic [31:0] DEF_T1_CYC   = 32'd1000;
  localparam logic [31:0] DEF_T2_CYC   = 32'd500;
  localparam logic [31:0] DEF_T3_CYC   = 32'd2000;
  localparam logic [31:0] DEF_T4_CYC   = 32'd2000;
  localparam logic [31:0] DEF_T5_CYC   = 32'd500;
  localparam logic [31:0] DEF_TOFF_CYC = 32'd5000;

  function automatic logic is_blank(input state_e s);
    return (s == S_OFF) || (s == S_VDD) || (s == S_LVDS) || (s == S_LVDS_DN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lvds_seq_timer: loadable saturating down-counter, expired when count is 0  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lvds_seq_timer #(
  parameter int unsigned        CNT_W   = 32,
  parameter logic [CNT_W-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lvds_panel_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lvds_panel_seq_ctrl: panel power sequencer and video gate for the LVDS path|
// | Optional fault input/flag enabled by defining LVDS_PANEL_FAULT_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lvds_panel_seq_ctrl
  import lvds_pkg::*;
#(
  parameter logic [31:0] T1_CYC   = DEF_T1_CYC,
  parameter logic [31:0] T2_CYC   = DEF_T2_CYC,
  parameter logic [31:0] T3_CYC   = DEF_T3_CYC,
  parameter logic [31:0] T4_CYC   = DEF_T4_CYC,
  parameter logic [31:0] T5_CYC   = DEF_T5_CYC,
  parameter logic [31:0] TOFF_CYC = DEF_TOFF_CYC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               I_clk_1x,
  input  logic               I_rst_n,
  input  logic               I_panel_en,
  input  logic               I_video_valid,
  input  logic [7:0]         I_R_data,
  input  logic [7:0]         I_G_data,
  input  logic [7:0]         I_B_data,
  input  logic               I_DE,
  input  logic               I_HS,
  input  logic               I_VS,
  output logic [7:0]         O_R_data,
  output logic [7:0]         O_G_data,
  output logic [7:0]         O_B_data,
  output logic               O_DE,
  output logic               O_HS,
  output logic               O_VS,
  output logic               O_panel_vdd,
  output logic               O_lvds_en,
  output logic               O_bl_en,
  output logic [STATE_W-1:0] O_state,
`ifdef LVDS_PANEL_FAULT_EN
  input  logic               I_fault,
  output logic               O_fault,
`endif
  output logic               O_ready
);

  // A zero-cycle setting still occupies one cycle in its state.
  function automatic logic [CNT_W-1:0] ld_val(input logic [31:0] t);
    return (t == 32'd0) ? '0 : CNT_W'(t - 32'd1);
  endfunction

  localparam logic [CNT_W-1:0] TOFF_LD = ld_val(TOFF_CYC);

  state_e           state_q, state_d;
  logic             vdd_q, vdd_d;
  logic             lvds_en_q, lvds_en_d;
  logic             bl_en_q, bl_en_d;
  logic             ready_q, ready_d;
  logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic             abort;
  logic             fault_trip;
  logic             fault_hold;
  logic             gate;
  logic             tmr_load;
  logic             tmr_expired;
  logic [CNT_W-1:0] tmr_load_val;

  assign abort = !I_panel_en || !I_video_valid;

`ifdef LVDS_PANEL_FAULT_EN
  logic fault_q, fault_d;

  assign fault_trip = I_fault && (state_q != S_OFF) && (state_q != S_LVDS_DN);
  assign fault_hold = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (fault_trip) begin
      fault_d = 1'b1;
    end else if ((state_q == S_OFF) && !I_panel_en) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge I_clk_1x) begin
    if (!I_rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign O_fault = fault_q;
`else
  assign fault_trip = 1'b0;
  assign fault_hold = 1'b0;
`endif

  // Abort outranks timer expiry; a fault outranks everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:     if (!abort && tmr_expired && !fault_hold) state_d = S_VDD;
      S_VDD:     if (abort) state_d = S_LVDS_DN; else if (tmr_expired) state_d = S_LVDS;
      S_LVDS:    if (abort) state_d = S_LVDS_DN; else if (tmr_expired) state_d = S_VIDEO;
      S_VIDEO:   if (abort) state_d = S_LVDS_DN; else if (tmr_expired) state_d = S_ON;
      S_ON:      if (abort) state_d = S_BL_DN;
      S_BL_DN:   if (tmr_expired) state_d = S_LVDS_DN;
      S_LVDS_DN: if (tmr_expired) state_d = S_OFF;
      default:   state_d = S_OFF;
    endcase
    if (fault_trip) begin
      state_d = S_LVDS_DN;
    end
  end

  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = '0;
    case (state_d)
      S_OFF:     tmr_load_val = TOFF_LD;
      S_VDD:     tmr_load_val = ld_val(T1_CYC);
      S_LVDS:    tmr_load_val = ld_val(T2_CYC);
      S_VIDEO:   tmr_load_val = ld_val(T3_CYC);
      S_BL_DN:   tmr_load_val = ld_val(T4_CYC);
      S_LVDS_DN: tmr_load_val = ld_val(T5_CYC);
      default:   tmr_load_val = '0;
    endcase
  end

  lvds_seq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (TOFF_LD)
  ) u_timer (
    .clk      (I_clk_1x),
    .rst_n    (I_rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  // Blank engages on the entry edge and releases one cycle after leaving a blanked state.
  always_comb begin
    vdd_d     = (state_d != S_OFF);
    lvds_en_d = (state_d == S_LVDS) || (state_d == S_VIDEO) ||
                (state_d == S_ON)   || (state_d == S_BL_DN);
    bl_en_d   = (state_d == S_ON);
    ready_d   = (state_d == S_ON);
    gate      = is_blank(state_q) || is_blank(state_d);
    r_d       = gate ? 8'h00 : I_R_data;
    g_d       = gate ? 8'h00 : I_G_data;
    b_d       = gate ? 8'h00 : I_B_data;
    de_d      = gate ? 1'b0  : I_DE;
    hs_d      = I_HS;
    vs_d      = I_VS;
  end

  always_ff @(posedge I_clk_1x) begin
    if (!I_rst_n) begin
      state_q   <= S_OFF;
      vdd_q     <= 1'b0;
      lvds_en_q <= 1'b0;
      bl_en_q   <= 1'b0;
      ready_q   <= 1'b0;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      vdd_q     <= vdd_d;
      lvds_en_q <= lvds_en_d;
      bl_en_q   <= bl_en_d;
      ready_q   <= ready_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign O_state     = state_q;
  assign O_panel_vdd = vdd_q;
  assign O_lvds_en   = lvds_en_q;
  assign O_bl_en     = bl_en_q;
  assign O_ready     = ready_q;
  assign O_R_data    = r_q;
  assign O_G_data    = g_q;
  assign O_B_data    = b_q;
  assign O_DE        = de_q;
  assign O_HS        = hs_q;
  assign O_VS        = vs_q;

endmodule
`default_nettype wire
